// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation bus path.
// Holds the bus address/data types, the access width enum, the arbiter
// FSM state type, the requester index type and the latched bus request.
package renode_pkg;

  typedef logic [63:0] address_t;
  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    ByteAccess,
    WordAccess,
    DoubleWordAccess,
    QuadWordAccess
  } valid_bits_e;

  // Widest supported requester count; the index type is sized for it.
  localparam int unsigned MaxRequesters = 16;
  typedef logic [$clog2(MaxRequesters)-1:0] requester_idx_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RESP,
    ARB_RESPOND
  } arbiter_state_e;

  typedef struct packed {
    logic        write;
    address_t    address;
    valid_bits_e data_bits;
    data_t       wdata;
  } bus_request_t;

endpackage

// File: rtl/renode_rr_picker.sv
// Combinational round-robin priority encoder.
// Ports:
//   valid_i - per-requester request vector
//   ptr_i   - requester with the highest priority this round
//   grant_o - one-hot grant (first valid at or after ptr_i, wrapping)
//   idx_o   - index of the granted requester
//   any_o   - at least one request is valid
module renode_rr_picker
  import renode_pkg::*;
#(
  parameter int unsigned Count = 2
) (
  input  logic [Count-1:0] valid_i,
  input  requester_idx_t   ptr_i,
  output logic [Count-1:0] grant_o,
  output requester_idx_t   idx_o,
  output logic             any_o
);

  // Two passes: first the upper segment [ptr, Count), then the wrapped
  // lower segment [0, ptr). The first hit in scan order wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < Count; i++) begin
      if (!any_o && valid_i[i] && i >= int'(ptr_i)) begin
        grant_o[i] = 1'b1;
        idx_o      = requester_idx_t'(i);
        any_o      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < Count; i++) begin
      if (!any_o && valid_i[i] && i < int'(ptr_i)) begin
        grant_o[i] = 1'b1;
        idx_o      = requester_idx_t'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/renode_bus_arbiter.sv
// Round-robin arbiter sharing one Renode bus controller port between
// RequestersCount requesters, with one transaction outstanding at a time
// and an optional downstream response timeout.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   req_*                  - per-requester request handshake and fields
//   resp_valid/rdata/error - one-cycle response pulse to the granted requester
//   bus_*                  - latched request towards the bus controller adapter
//   bus_resp_*             - downstream response
//   spurious_resp          - sticky flag: response seen with nothing outstanding
module renode_bus_arbiter
  import renode_pkg::*;
#(
  parameter int unsigned RequestersCount = 2,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic        [RequestersCount-1:0]       req_valid,
  output logic        [RequestersCount-1:0]       req_ready,
  input  logic        [RequestersCount-1:0]       req_write,
  input  address_t    [RequestersCount-1:0]       req_address,
  input  valid_bits_e [RequestersCount-1:0]       req_data_bits,
  input  data_t       [RequestersCount-1:0]       req_wdata,
  output logic        [RequestersCount-1:0]       resp_valid,
  output data_t                                   resp_rdata,
  output logic                                    resp_error,
  output logic                                    bus_valid,
  input  logic                                    bus_ready,
  output logic                                    bus_write,
  output address_t                                bus_address,
  output valid_bits_e                             bus_data_bits,
  output data_t                                   bus_wdata,
  input  logic                                    bus_resp_valid,
  input  data_t                                   bus_resp_rdata,
  input  logic                                    bus_resp_error,
  output logic                                    spurious_resp
);

  localparam bit          TimeoutEn   = (TimeoutCycles != 0);
  localparam logic [31:0] TimeoutLast = TimeoutEn ? TimeoutCycles - 1 : 32'd0;

  arbiter_state_e state_q, state_d;
  requester_idx_t ptr_q, grant_q;
  bus_request_t   req_q;
  logic [31:0]    cnt_q;
  data_t          rdata_q;
  logic           error_q;
  logic           spurious_q;

  logic [RequestersCount-1:0] pick_grant;
  requester_idx_t             pick_idx;
  logic                       pick_any;
  bus_request_t               pick_req;
  logic                       timeout_hit;

  renode_rr_picker #(.Count(RequestersCount)) u_picker (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Mux the granted requester's fields with the one-hot grant.
  always_comb begin
    pick_req = '0;
    for (int unsigned i = 0; i < RequestersCount; i++) begin
      if (pick_grant[i]) begin
        pick_req.write     = req_write[i];
        pick_req.address   = req_address[i];
        pick_req.data_bits = req_data_bits[i];
        pick_req.wdata     = req_wdata[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);
    unique case (state_q)
      ARB_IDLE: begin
        // A grant on a reset edge would be discarded, so do not advertise it.
        if (pick_any && rst_n) begin
          req_ready = pick_grant;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: if (bus_ready) state_d = ARB_WAIT_RESP;
      ARB_WAIT_RESP: begin
        // A response in the timeout cycle takes priority over the timeout.
        if (bus_resp_valid || timeout_hit) state_d = ARB_RESPOND;
      end
      ARB_RESPOND: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      req_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_resp_valid && state_q != ARB_WAIT_RESP) spurious_q <= 1'b1;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            req_q   <= pick_req;
          end
        end
        ARB_ISSUE: if (bus_ready) cnt_q <= '0;
        ARB_WAIT_RESP: begin
          cnt_q <= cnt_q + 32'd1;
          if (bus_resp_valid) begin
            rdata_q <= req_q.write ? '0 : bus_resp_rdata;
            error_q <= bus_resp_error;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            error_q <= 1'b1;
          end
        end
        ARB_RESPOND: begin
          if (grant_q == requester_idx_t'(RequestersCount - 1)) ptr_q <= '0;
          else ptr_q <= grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < RequestersCount; i++) begin
      resp_valid[i] = (state_q == ARB_RESPOND) && (grant_q == requester_idx_t'(i));
    end
  end

  assign resp_rdata    = (state_q == ARB_RESPOND) ? rdata_q : '0;
  assign resp_error    = (state_q == ARB_RESPOND) && error_q;
  assign bus_valid     = (state_q == ARB_ISSUE);
  assign bus_write     = req_q.write;
  assign bus_address   = req_q.address;
  assign bus_data_bits = req_q.data_bits;
  assign bus_wdata     = req_q.wdata;
  assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_renode_bus_arbiter.sv
// Scoreboard bench for renode_bus_arbiter: a driver issues requests and
// plays the bus side, pushing the expected response (requester, data,
// error, arrival cycle) into a queue; a monitor pops and compares on
// every resp_valid pulse.
module tb_renode_bus_arbiter;
  import renode_pkg::*;

  localparam int unsigned N = 3;
  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        [N-1:0] req_valid, req_ready, req_write, resp_valid;
  address_t    [N-1:0] req_address;
  valid_bits_e [N-1:0] req_data_bits;
  data_t       [N-1:0] req_wdata;
  data_t       resp_rdata, bus_wdata, bus_resp_rdata;
  logic        resp_error, bus_valid, bus_ready, bus_write;
  address_t    bus_address;
  valid_bits_e bus_data_bits;
  logic        bus_resp_valid, bus_resp_error, spurious_resp;

  renode_bus_arbiter #(.RequestersCount(N), .TimeoutCycles(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data_bits(req_data_bits), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_address(bus_address), .bus_data_bits(bus_data_bits), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_error(bus_resp_error), .spurious_resp(spurious_resp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned grant;
    data_t       rdata;
    logic        err;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned mptr = 0;  // model round-robin pointer

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int unsigned g);
    logic [N-1:0] one;
    one = 1;
    return one << g;
  endfunction

  // First requested index at or after the model pointer, wrapping.
  function automatic int unsigned pick(input logic [N-1:0] m);
    for (int unsigned k = 0; k < N; k++) begin
      if (m[(mptr + k) % N]) return (mptr + k) % N;
    end
    return N;
  endfunction

  task automatic rand_req(input int unsigned i);
    req_write[i]     = 1'($urandom_range(0, 1));
    req_address[i]   = {$urandom, $urandom};
    req_data_bits[i] = valid_bits_e'($urandom_range(0, 3));
    req_wdata[i]     = {$urandom, $urandom};
  endtask

  // One full transaction from IDLE. d = bus_ready delay, r = wait cycle of
  // the response (r >= T means never respond -> timeout).
  task automatic run_one(input int unsigned d, input int unsigned r,
                         input data_t rd, input logic er);
    int unsigned g, c0;
    logic to;
    bus_request_t x;
    exp_t e;
    g  = pick(req_valid);
    to = (r >= T);
    c0 = cyc;
    if (g >= N) begin
      chk("model_no_request", 0, 1);
      return;
    end
    x.write = req_write[g];
    x.address = req_address[g];
    x.data_bits = req_data_bits[g];
    x.wdata = req_wdata[g];
    e.grant = g;
    e.rdata = (to || x.write) ? '0 : rd;
    e.err   = to ? 1'b1 : er;
    // accept cycle is c0+1+d; waiting starts the cycle after
    e.at    = to ? c0 + 1 + d + T + 1 : c0 + 1 + d + 1 + r + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("req_ready_grant", req_ready, onehot(g));
    chk("bus_valid_c0", bus_valid, 0);
    tick();
    rand_req(g);  // new contents must not disturb the latched request
    for (int unsigned i = 0; i <= d; i++) begin
      bus_ready = (i == d);
      @(negedge clk);
      chk("bus_valid", bus_valid, 1);
      chk("bus_write", bus_write, x.write);
      chk("bus_address", bus_address, x.address);
      chk("bus_data_bits", bus_data_bits, x.data_bits);
      chk("bus_wdata", bus_wdata, x.wdata);
      if (i == 0) chk("req_ready_busy", req_ready, 0);
      tick();
    end
    bus_ready = 1'b0;
    if (!to) begin
      repeat (r) tick();
      bus_resp_valid = 1'b1;
      bus_resp_rdata = rd;
      bus_resp_error = er;
      tick();
      bus_resp_valid = 1'b0;
      bus_resp_rdata = {$urandom, $urandom};
      bus_resp_error = 1'($urandom_range(0, 1));
    end else begin
      repeat (T) tick();
    end
    tick();  // respond cycle, back to idle afterwards
    mptr = (g + 1) % N;
  endtask

  // Monitor
  exp_t me;
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp resp_valid=%b cycle=%0d", resp_valid, cyc);
      end else begin
        me = sb.pop_front();
        chk("resp_valid", resp_valid, onehot(me.grant));
        chk("resp_rdata", resp_rdata, me.rdata);
        chk("resp_error", resp_error, me.err);
        chk("resp_cycle", cyc, me.at);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    req_valid = '0; bus_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_resp_rdata = '0; bus_resp_error = 1'b0;
    for (int i = 0; i < N; i++) rand_req(i);
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_address", bus_address, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_spurious", spurious_resp, 0);
    tick();

    // Three requesters held continuously: grants 0,1,2,0,1,2
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", pick(req_valid), k % 3);
      run_one($urandom_range(0, 2), $urandom_range(0, 3), {$urandom, $urandom}, 1'b0);
    end

    // Single requester minimum-latency read
    req_valid = 3'b001;
    req_write[0] = 1'b0;
    run_one(0, 0, 64'hDEADBEEF, 1'b0);

    // Write to 0x1000 with bus_ready delayed 5 cycles
    req_write[0] = 1'b1;
    req_address[0] = 64'h1000;
    run_one(5, 1, 64'h1234_5678_9ABC_DEF0, 1'b0);

    // Timeout, then a late response sets spurious_resp
    req_valid = 3'b010;
    req_write[1] = 1'b0;
    run_one(0, T, '0, 1'b0);
    req_valid = '0;
    @(negedge clk);
    chk("spurious_before", spurious_resp, 0);
    tick();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 64'hBAD;
    tick();
    bus_resp_valid = 1'b0;
    @(negedge clk);
    chk("spurious_set", spurious_resp, 1);
    tick();

    // Response in the last allowed wait cycle beats the timeout
    req_valid = 3'b100;
    req_write[2] = 1'b0;
    run_one(1, T - 1, 64'h0BAD_F00D_CAFE_0001, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      req_valid = 3'($urandom_range(1, 7));
      run_one($urandom_range(0, 3), $urandom_range(0, T), {$urandom, $urandom},
              1'($urandom_range(0, 1)));
    end

    // Reset during WAIT_RESP abandons the transaction
    req_valid = 3'b100;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_bus_valid", bus_valid, 0);
    chk("rst2_resp_valid", resp_valid, 0);
    chk("rst2_resp_error", resp_error, 0);
    chk("rst2_bus_address", bus_address, 0);
    chk("rst2_spurious", spurious_resp, 0);
    mptr = 0;
    repeat (T + 3) tick();
    req_valid = '1;
    chk("rst2_first_turn", pick(req_valid), 0);
    run_one(0, 2, {$urandom, $urandom}, 1'b1);
    req_valid = '0;

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
